// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: IF/ID pipeline register with load-use stall, branch squash and sticky HALT.
module fetch_decode_reg #(
    parameter int            DW         = 16,
    parameter logic [DW-1:0] NOP_INSTR  = 16'h0800,
    parameter logic [DW-1:0] HALT_INSTR = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] if_instr,
    input  logic [DW-1:0] if_next_pc,
    input  logic          if_valid,
    input  logic          flush,
    input  logic          ex_mem_read,
    input  logic [2:0]    ex_wr_reg,
    output logic [DW-1:0] id_instr,
    output logic [DW-1:0] id_next_pc,
    output logic          id_valid,
    output logic          id_bubble,
    output logic          stall_out,
    output logic          halted
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t state, nextState;
    logic [DW-1:0] instrReg;
    logic [4:0] opcode;
    logic usesRs, usesRt, hazard, loadEn, squash, goHalt;
    assign id_instr = id_valid ? instrReg : NOP_INSTR;
    assign opcode = id_instr[15:11];
    assign usesRs = !(opcode inside {5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11000});
    assign usesRt = opcode inside {5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b11110, 5'b11111, 5'b10000, 5'b10011};
    assign hazard = id_valid && ex_mem_read &&
                    ((usesRs && id_instr[10:8] == ex_wr_reg) || (usesRt && id_instr[7:5] == ex_wr_reg));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= nextState;
    end
    always_comb begin
        nextState = state;
        loadEn    = 1'b0;
        squash    = 1'b0;
        goHalt    = 1'b0;
        stall_out = 1'b0;
        id_bubble = 1'b0;
        halted    = 1'b0;
        if (state == HALTED) begin
            stall_out = 1'b1;
            halted    = 1'b1;
        end else if (flush) begin
            squash = 1'b1;
        end else if (hazard) begin
            stall_out = 1'b1;
            id_bubble = 1'b1;
        end else begin
            loadEn = 1'b1;
            goHalt = id_valid && instrReg == HALT_INSTR;
            nextState = goHalt ? HALTED : RUN;
        end
    end
    // Nothing behind a HALT ever reaches decode, so the slot empties as HALT leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instrReg   <= NOP_INSTR;
            id_next_pc <= '0;
            id_valid   <= 1'b0;
        end else if (state == HALTED) begin
            id_valid <= 1'b0;
        end else if (squash) begin
            instrReg <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (loadEn) begin
            instrReg   <= if_instr;
            id_next_pc <= if_next_pc;
            id_valid   <= if_valid && !goHalt;
        end
    end
endmodule
